// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision K=7 Viterbi decoder, rate 1/2 or 1/3
// One ACS step per cycle over 64 states, serial minimum scan, then serial traceback.
module viterbi_decoder #(
  parameter int FRAME_LEN   = 192,
  parameter int PM_WIDTH    = 10,
  parameter int PM_INIT_BAD = 255,
  localparam int MAX_CONSTRAINT_LENGTH = 7,
  localparam int MAX_STATE_REG_NUM     = 6,
  localparam int MAX_STATE_NUM         = 64,
  localparam int MAX_CODE_RATE         = 3,
  localparam int RX_LEN                = MAX_CODE_RATE * FRAME_LEN
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    en_vd,
  input  logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0]     i_gen_poly,
  input  logic                                                    i_code_rate,
  input  logic [RX_LEN-1:0]                                       i_rx_data,
  input  logic [MAX_STATE_REG_NUM-1:0]                            i_prv_encoder_state,
  output logic [FRAME_LEN-1:0]                                    o_decoded_data,
  output logic [MAX_STATE_REG_NUM-1:0]                            o_end_state,
  output logic [PM_WIDTH-1:0]                                     o_path_metric,
  output logic                                                    o_busy,
  output logic                                                    o_decoder_done
);

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;
  localparam int   CNT_W = ($clog2(FRAME_LEN) > MAX_STATE_REG_NUM) ? $clog2(FRAME_LEN) : MAX_STATE_REG_NUM;

  typedef enum logic [2:0] {S_IDLE, S_ACS, S_MIN, S_TB, S_DONE} state_t;

  state_t                                               state_q, state_d;
  logic [CNT_W-1:0]                                     cnt;
  logic [RX_LEN-1:0]                                    rx_sh;
  logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0]  poly_q;
  logic                                                 rate_q;
  logic [PM_WIDTH-1:0]                                  metric   [MAX_STATE_NUM];
  logic [PM_WIDTH-1:0]                                  metric_d [MAX_STATE_NUM];
  logic [MAX_STATE_NUM-1:0]                             surv_d;
  logic [MAX_STATE_NUM-1:0]                             surv     [FRAME_LEN];
  logic [PM_WIDTH-1:0]                                  best_pm, scan_pm, min_pm;
  logic [MAX_STATE_REG_NUM-1:0]                         best_st, min_st, tb_s;
  logic                                                 scan_take;
  logic [MAX_CODE_RATE-1:0]                             sym;

  function automatic logic [1:0] branch_metric(
    input logic [MAX_CONSTRAINT_LENGTH-1:0]                    mux,
    input logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0] poly,
    input logic                                                rate3,
    input logic [MAX_CODE_RATE-1:0]                            rx_sym
  );
    logic [MAX_CODE_RATE-1:0] diff;
    for (int i = 0; i < MAX_CODE_RATE; i++) diff[i] = (^(mux & poly[i])) ^ rx_sym[i];
    if (!rate3) diff[2] = 1'b0;
    return 2'(diff[0]) + 2'(diff[1]) + 2'(diff[2]);
  endfunction

  // Symbol for the current step always sits at the top of the shifted copy.
  assign sym = {rx_sh[RX_LEN-3], rx_sh[RX_LEN-2], rx_sh[RX_LEN-1]};

  for (genvar g = 0; g < MAX_STATE_NUM; g++) begin : g_acs
    localparam logic [MAX_STATE_REG_NUM-1:0] N = MAX_STATE_REG_NUM'(g);
    logic [PM_WIDTH-1:0] cand0, cand1;
    assign cand0 = metric[{1'b0, N[5:1]}] + PM_WIDTH'(branch_metric({1'b0, N}, poly_q, rate_q, sym));
    assign cand1 = metric[{1'b1, N[5:1]}] + PM_WIDTH'(branch_metric({1'b1, N}, poly_q, rate_q, sym));
    assign surv_d[g]   = (cand1 < cand0);
    assign metric_d[g] = surv_d[g] ? cand1 : cand0;
  end

  assign scan_pm   = metric[cnt[MAX_STATE_REG_NUM-1:0]];
  assign scan_take = (cnt == '0) || (scan_pm < best_pm);
  assign min_pm    = scan_take ? scan_pm : best_pm;
  assign min_st    = scan_take ? cnt[MAX_STATE_REG_NUM-1:0] : best_st;

  assign o_busy         = (state_q == S_ACS) || (state_q == S_MIN) || (state_q == S_TB);
  assign o_decoder_done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en_vd) state_d = S_ACS;
      S_ACS:  if (!en_vd) state_d = S_IDLE;
              else if (cnt == CNT_W'(FRAME_LEN - 1)) state_d = S_MIN;
      S_MIN:  if (!en_vd) state_d = S_IDLE;
              else if (cnt == CNT_W'(MAX_STATE_NUM - 1)) state_d = S_TB;
      S_TB:   if (!en_vd) state_d = S_IDLE;
              else if (cnt == '0) state_d = S_DONE;
      S_DONE: if (!en_vd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      rx_sh          <= '0;
      poly_q         <= '0;
      rate_q         <= CODE_RATE_2;
      best_pm        <= '0;
      best_st        <= '0;
      tb_s           <= '0;
      o_decoded_data <= '0;
      o_end_state    <= '0;
      o_path_metric  <= '0;
      for (int i = 0; i < MAX_STATE_NUM; i++) metric[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (en_vd) begin
          rx_sh  <= i_rx_data;
          poly_q <= i_gen_poly;
          rate_q <= i_code_rate;
          cnt    <= '0;
          for (int i = 0; i < MAX_STATE_NUM; i++)
            metric[i] <= (MAX_STATE_REG_NUM'(i) == i_prv_encoder_state) ? '0 : PM_WIDTH'(PM_INIT_BAD);
        end
        S_ACS: begin
          for (int i = 0; i < MAX_STATE_NUM; i++) metric[i] <= metric_d[i];
          rx_sh <= (rate_q == CODE_RATE_3) ? (rx_sh << 3) : (rx_sh << 2);
          cnt   <= (cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : cnt + 1'b1;
        end
        S_MIN: begin
          best_pm <= min_pm;
          best_st <= min_st;
          if (cnt == CNT_W'(MAX_STATE_NUM - 1)) begin
            o_end_state   <= min_st;
            o_path_metric <= min_pm;
            tb_s          <= min_st;
            cnt           <= CNT_W'(FRAME_LEN - 1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TB: begin
          // Last info bit is traced first; shifting down lands it at bit 0.
          o_decoded_data <= {tb_s[0], o_decoded_data[FRAME_LEN-1:1]};
          tb_s           <= {surv[cnt][tb_s], tb_s[MAX_STATE_REG_NUM-1:1]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_ACS) surv[cnt] <= surv_d;
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - directed scoreboard bench for viterbi_decoder
module tb_viterbi_decoder;

  logic              clk = 1'b0;
  logic              rst;
  logic              en_vd;
  logic [2:0][6:0]   gen_poly;
  logic              code_rate;
  logic [575:0]      rx_data;
  logic [5:0]        prv_state;
  logic [191:0]      decoded;
  logic [5:0]        end_state;
  logic [9:0]        path_metric;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [191:0] data;
    logic [5:0]   st;
    logic [9:0]   pm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;

  viterbi_decoder dut (
    .clk                 (clk),
    .rst                 (rst),
    .en_vd               (en_vd),
    .i_gen_poly          (gen_poly),
    .i_code_rate         (code_rate),
    .i_rx_data           (rx_data),
    .i_prv_encoder_state (prv_state),
    .o_decoded_data      (decoded),
    .o_end_state         (end_state),
    .o_path_metric       (path_metric),
    .o_busy              (busy),
    .o_decoder_done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void encode(input logic [191:0] d, input logic [5:0] st0, input logic r3,
                                 input logic [2:0][6:0] poly,
                                 output logic [575:0] rx, output logic [5:0] st_end);
    logic [5:0] s;
    logic [6:0] mux;
    int         r;
    r  = r3 ? 3 : 2;
    s  = st0;
    rx = '0;
    for (int t = 0; t < 192; t++) begin
      mux = {s, d[191-t]};
      for (int i = 0; i < r; i++) rx[575 - r*t - i] = ^(mux & poly[i]);
      s = {s[4:0], d[191-t]};
    end
    st_end = s;
  endfunction

  task automatic start_frame(input logic [191:0] d, input logic [5:0] st0, input logic r3,
                             input logic [575:0] flip, input int n_err, input bit push,
                             output logic [5:0] st_end);
    logic [575:0] rx;
    exp_t         e;
    encode(d, st0, r3, gen_poly, rx, st_end);
    @(negedge clk);
    code_rate = r3;
    rx_data   = rx ^ flip;
    prv_state = st0;
    en_vd     = 1'b1;
    e.data = d;
    e.st   = st_end;
    e.pm   = 10'(n_err);
    if (push) sb_q.push_back(e);
  endtask

  task automatic finish_frame(input string tag, output int done_edge);
    int   lat;
    exp_t e;
    lat = 0;
    @(posedge clk);
    #1;
    while (!done && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
    end
    done_edge = edge_cnt;
    check({tag, "_latency"}, 192'(lat), 192'd448);
    check({tag, "_busy"}, 192'(busy), 192'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 192'd1, 192'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_data"}, decoded, e.data);
      check({tag, "_end_state"}, 192'(end_state), 192'(e.st));
      check({tag, "_metric"}, 192'(path_metric), 192'(e.pm));
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    en_vd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [191:0] d_b, d_b2, d_f, d_a5;
    logic [575:0] flip3;
    logic [5:0]   st_a, st_b, st_b2, st_x;
    int           e1, e2, ex;

    rst       = 1'b0;
    en_vd     = 1'b0;
    code_rate = 1'b0;
    rx_data   = '0;
    prv_state = '0;
    gen_poly[0] = 7'b1111001;
    gen_poly[1] = 7'b1011011;
    gen_poly[2] = 7'b0000000;
    for (int i = 0; i < 6; i++) begin
      d_b[i*32 +: 32]  = $urandom;
      d_b2[i*32 +: 32] = $urandom;
      d_f[i*32 +: 32]  = $urandom;
    end
    d_a5  = {24{8'hA5}};
    flip3 = '0;
    flip3[575 - 3*20]  = 1'b1;
    flip3[575 - 3*70]  = 1'b1;
    flip3[575 - 3*120] = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_data", decoded, 192'd0);
    check("reset_end_state", 192'(end_state), 192'd0);
    check("reset_metric", 192'(path_metric), 192'd0);
    check("reset_busy", 192'(busy), 192'd0);
    check("reset_done", 192'(done), 192'd0);
    @(negedge clk);
    rst = 1'b1;

    start_frame('0, 6'd0, 1'b0, '0, 0, 1'b1, st_a);
    finish_frame("r2_zero", e1);
    idle_gap();

    start_frame(d_b, 6'h2A, 1'b0, '0, 0, 1'b1, st_b);
    finish_frame("r2_rand", e1);
    @(negedge clk);
    en_vd = 1'b0;
    start_frame(d_b2, st_b, 1'b0, '0, 0, 1'b1, st_b2);
    finish_frame("b2b_second", e2);
    check("b2b_period", 192'(e2 - e1), 192'd450);
    idle_gap();

    start_frame(d_b, 6'h2A, 1'b0, 576'd1 << 400, 1, 1'b1, st_x);
    finish_frame("r2_one_err", e1);
    idle_gap();

    gen_poly[2] = 7'b1110101;
    start_frame(d_a5, 6'd0, 1'b1, '0, 0, 1'b1, st_x);
    finish_frame("r3_a5", e1);
    idle_gap();
    start_frame(d_a5, 6'd0, 1'b1, flip3, 3, 1'b1, st_x);
    finish_frame("r3_three_err", e1);
    idle_gap();

    start_frame(d_f, 6'h11, 1'b1, '0, 0, 1'b0, st_x);
    @(posedge clk);
    repeat (99) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 192'(busy), 192'd1);
    en_vd = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_after", 192'(busy), 192'd0);
    ex = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) ex++;
    end
    check("abort_no_done", 192'(ex), 192'd0);

    start_frame(d_f, 6'h11, 1'b1, flip3, 3, 1'b0, st_x);
    @(posedge clk);
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_data", decoded, 192'd0);
    check("async_rst_end_state", 192'(end_state), 192'd0);
    check("async_rst_metric", 192'(path_metric), 192'd0);
    check("async_rst_busy", 192'(busy), 192'd0);
    check("async_rst_done", 192'(done), 192'd0);
    @(negedge clk);
    en_vd = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    start_frame(d_f, 6'h11, 1'b1, '0, 0, 1'b1, st_x);
    finish_frame("after_reset", e1);
    idle_gap();

    check("scoreboard_drained", 192'(sb_q.size()), 192'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
